fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 29 ++
 rtl/fetch_ctrl_sat_counter.sv | 43 ++++
 rtl/fetch_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg -- shared types and constants for the instruction-fetch
// controller.
//   PERF_W_DEFAULT : default width of the optional performance counters
//   fetch_state_e  : FSM state encoding. state_o exposes this encoding for debug.
//   branch_window  : true in the states where a taken branch is acted on.
package fetch_ctrl_pkg;

  localparam int unsigned PERF_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_STALL    = 3'd3,
    ST_REDIRECT = 3'd4
  } fetch_state_e;

  // HOLD has no valid PC yet. REDIRECT already carries a bubble in EX.
  // A taken branch is ignored in both of them.
  function automatic logic branch_window(input fetch_state_e s);
    logic ok;
    case (s)
      ST_FETCH, ST_MEM_WAIT, ST_STALL: ok = 1'b1;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// sat_counter -- event counter that saturates at all-ones.
//   clk     : clock
//   rst_n   : asynchronous active-low reset (clears the count)
//   inc_i   : count one event at the coming edge
//   clear_i : synchronous clear; takes priority over inc_i
//   value_o : current count (registered)
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins. Otherwise increment until all-ones, then hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction-fetch control FSM. It drives the PC enable, the
// branch selects and the pipeline flushes.
//   clk, reset            : clock, asynchronous active-low reset
//   imem_ready            : instruction memory returns the fetch this cycle
//   stall                 : hazard unit freeze request for IF/ID
//   br_valid/taken/uncond : branch resolution from EX
//   imem_req, pc_en       : fetch request, PC load enable
//   br_sel, uncond_sel    : PC datapath selects
//   flush_if, flush_id    : pipeline register invalidates
//   state_o               : current state encoding (debug)
//   perf_*_cnt            : saturating counters, present only when
//                           FETCH_CTRL_PERF_EN is defined
// Outputs are Mealy: they are decoded from the state register and the
// current inputs.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned PERF_W = PERF_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       imem_ready,
  input  logic       stall,
  input  logic       br_valid,
  input  logic       br_taken,
  input  logic       br_uncond,
  output logic       imem_req,
  output logic       pc_en,
  output logic       br_sel,
  output logic       uncond_sel,
  output logic       flush_if,
  output logic       flush_id,
  output logic [2:0] state_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt,
  output logic [PERF_W-1:0] perf_wait_cnt
`endif
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         redirect_s;
  logic         imem_req_s;
  logic         pc_en_s;
  logic         br_sel_s;
  logic         uncond_sel_s;
  logic         flush_if_s;
  logic         flush_id_s;

  // A taken branch that is accepted this cycle. It overrides stall and imem_ready.
  assign redirect_s = br_valid & br_taken & branch_window(state_q);

  // Next-state and Mealy output decode.
  always_comb begin
    state_d      = state_q;
    imem_req_s   = 1'b0;
    pc_en_s      = 1'b0;
    br_sel_s     = 1'b0;
    uncond_sel_s = 1'b0;
    flush_if_s   = 1'b0;
    flush_id_s   = 1'b0;
    if (redirect_s) begin
      // imem_req still follows the state. Any outstanding fetch is dropped
      // because REDIRECT ignores imem_ready.
      imem_req_s   = (state_q != ST_STALL);
      pc_en_s      = 1'b1;
      br_sel_s     = 1'b1;
      uncond_sel_s = br_uncond;
      flush_if_s   = 1'b1;
      flush_id_s   = 1'b1;
      state_d      = ST_REDIRECT;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          imem_req_s = 1'b1;
          if (stall) begin
            state_d = ST_STALL;
          end else if (!imem_ready) begin
            state_d = ST_MEM_WAIT;
          end else begin
            pc_en_s = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_MEM_WAIT: begin
          // Stall is only examined once the pending fetch has returned.
          imem_req_s = 1'b1;
          if (!imem_ready) begin
            state_d = ST_MEM_WAIT;
          end else if (stall) begin
            state_d = ST_STALL;
          end else begin
            pc_en_s = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_STALL: begin
          if (stall) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_REDIRECT: begin
          flush_if_s = 1'b1;
          state_d    = ST_FETCH;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  // State register. Reset forces HOLD without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Gating with reset holds every output at 0 while reset is asserted, even
  // though the inputs are live.
  assign imem_req   = reset & imem_req_s;
  assign pc_en      = reset & pc_en_s;
  assign br_sel     = reset & br_sel_s;
  assign uncond_sel = reset & uncond_sel_s;
  assign flush_if   = reset & flush_if_s;
  assign flush_id   = reset & flush_id_s;
  assign state_o    = state_q;

`ifdef FETCH_CTRL_PERF_EN
  sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (state_q == ST_STALL),
    .clear_i (1'b0),
    .value_o (perf_stall_cnt)
  );

  sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (redirect_s),
    .clear_i (1'b0),
    .value_o (perf_flush_cnt)
  );

  sat_counter #(.WIDTH(PERF_W)) u_wait_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (state_q == ST_MEM_WAIT),
    .clear_i (1'b0),
    .value_o (perf_wait_cnt)
  );
`else
  // PERF_W only sizes the counter ports. This build omits those ports.
  if (PERF_W == 0) begin : g_perf_w_unused
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl. A rule-based reference
// model predicts every output in every cycle. The bench runs directed sequences
// with hand-computed expectations, and then randomized traffic.
// Perf counter checks are active when FETCH_CTRL_PERF_EN is defined.
module tb_fetch_ctrl;

  localparam int TB_PERF_W = 4;
  localparam int SAT_MAX   = (1 << TB_PERF_W) - 1;
  localparam int S_HOLD    = 0;
  localparam int S_FETCH   = 1;
  localparam int S_MW      = 2;
  localparam int S_STALL   = 3;
  localparam int S_REDIR   = 4;

  logic       clk;
  logic       reset;
  logic       imem_ready;
  logic       stall;
  logic       br_valid;
  logic       br_taken;
  logic       br_uncond;
  logic       imem_req;
  logic       pc_en;
  logic       br_sel;
  logic       uncond_sel;
  logic       flush_if;
  logic       flush_id;
  logic [2:0] state_o;
`ifdef FETCH_CTRL_PERF_EN
  logic [TB_PERF_W-1:0] perf_stall_cnt;
  logic [TB_PERF_W-1:0] perf_flush_cnt;
  logic [TB_PERF_W-1:0] perf_wait_cnt;
`endif

  int n_checks;
  int n_errors;

  // Reference model state
  int m_state;
  int m_stall_c;
  int m_flush_c;
  int m_wait_c;

  // Outputs observed in the most recent cycle, for directed checks
  int o_req, o_pc, o_bsel, o_usel, o_fif, o_fid, o_state;
  int o_pstall, o_pflush, o_pwait;

  fetch_ctrl #(.PERF_W(TB_PERF_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_ready (imem_ready),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .br_uncond  (br_uncond),
    .imem_req   (imem_req),
    .pc_en      (pc_en),
    .br_sel     (br_sel),
    .uncond_sel (uncond_sel),
    .flush_if   (flush_if),
    .flush_id   (flush_id),
    .state_o    (state_o)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= SAT_MAX) ? SAT_MAX : v + 1;
  endfunction

  // Rule-based prediction. outs = {req, pc_en, br_sel, uncond_sel, flush_if, flush_id}.
  function automatic void predict(input int st, input logic rst, input logic rdy,
                                  input logic stl, input logic bv, input logic bt,
                                  input logic bu, output logic [5:0] outs,
                                  output int nxt, output logic took);
    logic fetching;
    outs = 6'd0;
    nxt  = S_HOLD;
    took = 1'b0;
    if (rst) begin
      fetching = (st == S_FETCH) || (st == S_MW);
      took     = bv && bt && (fetching || st == S_STALL);
      outs[5]  = fetching;
      outs[4]  = took || (fetching && rdy && !stl);
      outs[3]  = took;
      outs[2]  = took && bu;
      outs[1]  = took || (st == S_REDIR);
      outs[0]  = took;
      if (took)                              nxt = S_REDIR;
      else if (st == S_HOLD || st == S_REDIR) nxt = S_FETCH;
      else if (st == S_STALL)                nxt = stl ? S_STALL : S_FETCH;
      else if (st == S_FETCH)                nxt = stl ? S_STALL : (rdy ? S_FETCH : S_MW);
      else                                   nxt = !rdy ? S_MW : (stl ? S_STALL : S_FETCH);
    end
  endfunction

  // One clock cycle. The task is entered 1 ns after a rising edge and returns
  // 1 ns after the next one. Outputs are compared at the falling edge, and the
  // model advances at the rising edge.
  task automatic run_cycle(input logic rdy, input logic stl, input logic bv,
                           input logic bt, input logic bu);
    logic [5:0] e;
    int         nxt;
    logic       took;
    imem_ready = rdy;
    stall      = stl;
    br_valid   = bv;
    br_taken   = bt;
    br_uncond  = bu;
    @(negedge clk);
    predict(m_state, reset, rdy, stl, bv, bt, bu, e, nxt, took);
    o_req   = int'(imem_req);
    o_pc    = int'(pc_en);
    o_bsel  = int'(br_sel);
    o_usel  = int'(uncond_sel);
    o_fif   = int'(flush_if);
    o_fid   = int'(flush_id);
    o_state = int'(state_o);
    chk("imem_req",   o_req,   int'(e[5]));
    chk("pc_en",      o_pc,    int'(e[4]));
    chk("br_sel",     o_bsel,  int'(e[3]));
    chk("uncond_sel", o_usel,  int'(e[2]));
    chk("flush_if",   o_fif,   int'(e[1]));
    chk("flush_id",   o_fid,   int'(e[0]));
    chk("state_o",    o_state, m_state);
`ifdef FETCH_CTRL_PERF_EN
    o_pstall = int'(perf_stall_cnt);
    o_pflush = int'(perf_flush_cnt);
    o_pwait  = int'(perf_wait_cnt);
    chk("perf_stall_cnt", o_pstall, m_stall_c);
    chk("perf_flush_cnt", o_pflush, m_flush_c);
    chk("perf_wait_cnt",  o_pwait,  m_wait_c);
`endif
    @(posedge clk);
    if (reset) begin
      if (m_state == S_STALL) m_stall_c = sat_inc(m_stall_c);
      if (m_state == S_MW)    m_wait_c  = sat_inc(m_wait_c);
      if (took)               m_flush_c = sat_inc(m_flush_c);
      m_state = nxt;
    end
    #1;
  endtask

  task automatic model_reset();
    m_state   = S_HOLD;
    m_stall_c = 0;
    m_flush_c = 0;
    m_wait_c  = 0;
  endtask

  // Holds reset for two cycles (a taken branch is offered and must be
  // ignored), then releases reset between clock edges.
  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
  endtask

  initial begin
    int pulses;
    int waits;
    int stalls;
    n_checks   = 0;
    n_errors   = 0;
    o_pstall   = 0;
    o_pflush   = 0;
    o_pwait    = 0;
    reset      = 1'b0;
    imem_ready = 1'b0;
    stall      = 1'b0;
    br_valid   = 1'b0;
    br_taken   = 1'b0;
    br_uncond  = 1'b0;
    model_reset();

    // Reset state before any clock edge.
    #1;
    chk("rst_imem_req", int'(imem_req), 0);
    chk("rst_pc_en",    int'(pc_en),    0);
    chk("rst_flush_if", int'(flush_if), 0);
    chk("rst_state",    int'(state_o),  0);
    @(posedge clk);
    #1;

    // Free run: HOLD for one cycle, then pc_en every cycle -> 9 pulses in 10 cycles.
    apply_reset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 0) chk("first_cycle_hold", o_state, 0);
      pulses += o_pc;
    end
    chk("pc_en_pulses_10", pulses, 9);

    // imem_ready low for 3 cycles from FETCH -> 3 MEM_WAIT cycles.
    apply_reset();
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wait_entry_state", o_state, 1);
    waits = 0;
    for (int i = 0; i < 2; i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      waits += (o_state == 2) ? 1 : 0;
      chk("wait_pc_en", o_pc, 0);
    end
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    waits += (o_state == 2) ? 1 : 0;
    chk("ready_pc_en", o_pc, 1);
    chk("mem_wait_cycles", waits, 3);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("back_to_fetch", o_state, 1);
`ifdef FETCH_CTRL_PERF_EN
    chk("lit_perf_wait", o_pwait, 3);
`endif

    // Stall and an unconditional taken branch in the same cycle: the branch wins.
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("br_pc_en", o_pc, 1);
    chk("br_br_sel", o_bsel, 1);
    chk("br_uncond_sel", o_usel, 1);
    chk("br_flush_if", o_fif, 1);
    chk("br_flush_id", o_fid, 1);
    // A second taken branch during REDIRECT is ignored.
    run_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("redir_state", o_state, 4);
    chk("redir_flush_if", o_fif, 1);
    chk("redir_flush_id", o_fid, 0);
    chk("redir_pc_en", o_pc, 0);
    chk("redir_br_sel", o_bsel, 0);
    chk("redir_imem_req", o_req, 0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("redir_then_fetch", o_state, 1);

    // Taken branch on the 2nd MEM_WAIT cycle. The late imem_ready is dropped.
    apply_reset();
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("mw_br_state", o_state, 2);
    chk("mw_br_pc_en", o_pc, 1);
    chk("mw_br_uncond_sel", o_usel, 0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mw_redir_state", o_state, 4);
    chk("mw_redir_pc_en", o_pc, 0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_CTRL_PERF_EN
    chk("lit_perf_flush", o_pflush, 1);
`endif

    // Asynchronous reset in the middle of STALL, between clock edges.
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    chk("pre_reset_stall", int'(state_o), 3);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_imem_req", int'(imem_req), 0);
    chk("async_pc_en",    int'(pc_en),    0);
    chk("async_flush_if", int'(flush_if), 0);
    chk("async_state",    int'(state_o),  0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_hold", o_state, 0);
    chk("post_reset_pc_en", o_pc, 0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_fetch", o_state, 1);
    chk("post_reset_pc_en2", o_pc, 1);

    // Stall held for 20 cycles: 19 STALL cycles, and a 4-bit counter saturates at 15.
    apply_reset();
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      stalls += (o_state == 3) ? 1 : 0;
    end
    chk("stall_cycles", stalls, 19);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_CTRL_PERF_EN
    chk("lit_perf_stall_sat", o_pstall, 15);
`endif

    // Randomized traffic against the model, with occasional resets.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        run_cycle(logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 4) == 0),
                  logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
